// File: rtl/subr1r2r3_seq.sv
`default_nettype none
// ============================================================================
//  Module      : subr1r2r3_seq
//  Description : Multi-cycle digit-serial subtractor r1 = r2 - r3 with NZCV
//                flags. DIGIT bits of r2 + ~r3 + 1 are summed per clock;
//                results are registered and held until the next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module subr1r2r3_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r1,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    // Number of digit steps per operation and the counter width to hold K-1.
    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(K - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // A DIGIT that does not divide WIDTH would leave a partial digit behind.
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("subr1r2r3_seq: DIGIT must divide WIDTH");
    end

    logic [0:0]       r_state_q,   w_state_d;
    logic [WIDTH-1:0] r_a_q,       w_a_d;
    logic [WIDTH-1:0] r_b_q,       w_b_d;
    logic             r_carry_q,   w_carry_d;
    logic [WIDTH-1:0] r_res_q,     w_res_d;
    logic [CW-1:0]    r_cnt_q,     w_cnt_d;
    logic             r_r2_msb_q,  w_r2_msb_d;
    logic             r_r3_msb_q,  w_r3_msb_d;
    logic             r_busy_q,    w_busy_d;
    logic             r_done_q,    w_done_d;
    logic [WIDTH-1:0] r_r1_q,      w_r1_d;
    logic             r_n_q,       w_n_d;
    logic             r_z_q,       w_z_d;
    logic             r_c_q,       w_c_d;
    logic             r_v_q,       w_v_d;

    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_res_shift;

    // Digit adder and result shift register input (new digit enters at MSB).
    always_comb begin
        w_sum       = {1'b0, r_a_q[DIGIT-1:0]} + {1'b0, r_b_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, r_carry_q};
        w_res_shift = (r_res_q >> DIGIT)
                    | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // Next-state logic: capture on start, step one digit per clock in RUN.
    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_carry_d  = r_carry_q;
        w_res_d    = r_res_q;
        w_cnt_d    = r_cnt_q;
        w_r2_msb_d = r_r2_msb_q;
        w_r3_msb_d = r_r3_msb_q;
        w_busy_d   = r_busy_q;
        w_done_d   = 1'b0;
        w_r1_d     = r_r1_q;
        w_n_d      = r_n_q;
        w_z_d      = r_z_q;
        w_c_d      = r_c_q;
        w_v_d      = r_v_q;

        case (r_state_q)
            c_IDLE: begin
                if (start) begin
                    // Subtraction as r2 + ~r3 + 1: invert B, seed carry with 1.
                    w_a_d      = r2;
                    w_b_d      = ~r3;
                    w_carry_d  = 1'b1;
                    w_res_d    = '0;
                    w_cnt_d    = '0;
                    w_r2_msb_d = r2[WIDTH-1];
                    w_r3_msb_d = r3[WIDTH-1];
                    w_busy_d   = 1'b1;
                    w_state_d  = c_RUN;
                end
            end
            c_RUN: begin
                w_a_d     = r_a_q >> DIGIT;
                w_b_d     = r_b_q >> DIGIT;
                w_carry_d = w_sum[DIGIT];
                w_res_d   = w_res_shift;
                w_cnt_d   = r_cnt_q + CW'(1);
                if (r_cnt_q == c_LAST) begin
                    // Last digit: publish result and flags in one step.
                    w_r1_d    = w_res_shift;
                    w_n_d     = w_res_shift[WIDTH-1];
                    w_z_d     = (w_res_shift == '0);
                    w_c_d     = w_sum[DIGIT];
                    w_v_d     = (r_r2_msb_q != r_r3_msb_q)
                             && (w_res_shift[WIDTH-1] != r_r2_msb_q);
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = c_IDLE;
                end
            end
            default: begin
                w_state_d = c_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= c_IDLE;
            r_a_q      <= '0;
            r_b_q      <= '0;
            r_carry_q  <= 1'b0;
            r_res_q    <= '0;
            r_cnt_q    <= '0;
            r_r2_msb_q <= 1'b0;
            r_r3_msb_q <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
            r_r1_q     <= '0;
            r_n_q      <= 1'b0;
            r_z_q      <= 1'b0;
            r_c_q      <= 1'b0;
            r_v_q      <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_a_q      <= w_a_d;
            r_b_q      <= w_b_d;
            r_carry_q  <= w_carry_d;
            r_res_q    <= w_res_d;
            r_cnt_q    <= w_cnt_d;
            r_r2_msb_q <= w_r2_msb_d;
            r_r3_msb_q <= w_r3_msb_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
            r_r1_q     <= w_r1_d;
            r_n_q      <= w_n_d;
            r_z_q      <= w_z_d;
            r_c_q      <= w_c_d;
            r_v_q      <= w_v_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign r1   = r_r1_q;
    assign n    = r_n_q;
    assign z    = r_z_q;
    assign c    = r_c_q;
    assign v    = r_v_q;

endmodule
`default_nettype wire
